// File: rtl/gmii_phy_speed_ctrl.sv
// gmii_phy_speed_ctrl
//   MDIO poller for one GMII PHY port. It periodically reads the PHY status register
//   with a clause-22 read frame, decodes link state and resolved speed, and drives
//   mii_select / speed / link_up towards the MAC.
//
//   Frame: 64 MDC periods, MSB first. PRE (32 x 1), CMD (01 10 PHY_ADDR REG_ADDR),
//   TA (2 bits, released), DATA (16 bits, released, shifted in on MDC rise).
//   MDIO outputs change in the clk cycle MDC falls. mdio_i is sampled in the clk
//   cycle MDC rises.
//
//   Optional feature macro: GMII_SPEED_DEBOUNCE_EN. When defined, a new speed/link
//   value is accepted only once two consecutive frames return the same
//   speed+link bits.
//
// Ports
//   clk          system clock, all logic on posedge
//   rst_n        synchronous reset, active low
//   poll_en      1 = polling enabled
//   mdc          MDIO clock (low while idle)
//   mdio_o       MDIO data out
//   mdio_oe      MDIO output enable (1 = drive)
//   mdio_i       MDIO data in
//   mii_select   1 = 10/100M (MII tx clock), 0 = 1000M
//   speed        00 = 10M, 01 = 100M, 10 = 1000M
//   link_up      last accepted link status
//   speed_change 1-cycle pulse when speed/mii_select update
//   rd_data      raw data of the last completed read
//   busy         high from PRE through DONE inclusive
module gmii_phy_speed_ctrl #(
   parameter int unsigned CLK_DIV       = 25,
   parameter logic [4:0]  PHY_ADDR      = 5'd0,
   parameter logic [4:0]  REG_ADDR      = 5'h11,
   parameter int unsigned SPEED_MSB     = 15,
   parameter int unsigned LINK_BIT      = 10,
   parameter int unsigned POLL_INTERVAL = 1250000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        poll_en,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i,
   output logic        mii_select,
   output logic [1:0]  speed,
   output logic        link_up,
   output logic        speed_change,
   output logic [15:0] rd_data,
   output logic        busy
);

   localparam int unsigned     DivW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
   localparam logic [31:0]     IntLoad = 32'(POLL_INTERVAL);
   // Driven part of the frame: preamble, start, read opcode, PHY and register address.
   localparam logic [45:0]     TxBits  = {32'hFFFF_FFFF, 2'b01, 2'b10, PHY_ADDR, REG_ADDR};

   typedef enum logic [2:0] {
      StIdle, StPre, StCmd, StTa, StData, StDone, StWait
   } state_e;

   state_e          state_q, state_d;
   logic [DivW-1:0] div_q, div_d;
   logic            mdc_q, mdc_d;
   logic [5:0]      bit_q, bit_d;
   logic [15:0]     shift_q, shift_d;
   logic            mdio_o_q, mdio_o_d;
   logic            mdio_oe_q, mdio_oe_d;
   logic [31:0]     int_q, int_d;
   logic [15:0]     rd_data_q, rd_data_d;
   logic            link_q, link_d;
   logic [1:0]      speed_q, speed_d;
   logic            mii_q, mii_d;
   logic            chg_q, chg_d;

   logic [1:0]      new_field;
   logic            new_link;
   logic            accept;

   assign new_field = shift_q[SPEED_MSB -: 2];
   assign new_link  = shift_q[LINK_BIT];

`ifdef GMII_SPEED_DEBOUNCE_EN
   // Candidate from the previous frame; a value is accepted when it repeats.
   logic [2:0] prev_q;
   logic       prev_vld_q;

   assign accept = prev_vld_q && (prev_q == {new_field, new_link});

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         prev_q     <= 3'd0;
         prev_vld_q <= 1'b0;
      end else if (state_q == StDone) begin
         prev_q     <= {new_field, new_link};
         prev_vld_q <= 1'b1;
      end
   end
`else
   assign accept = 1'b1;
`endif

   function automatic logic tx_bit(input logic [5:0] idx);
      if (idx < 6'd46) return TxBits[6'd45 - idx];
      return 1'b1;
   endfunction

   function automatic state_e phase_of(input logic [5:0] idx);
      if (idx < 6'd32) return StPre;
      if (idx < 6'd46) return StCmd;
      if (idx < 6'd48) return StTa;
      return StData;
   endfunction

   always_comb begin
      state_d   = state_q;
      div_d     = div_q;
      mdc_d     = mdc_q;
      bit_d     = bit_q;
      shift_d   = shift_q;
      mdio_o_d  = mdio_o_q;
      mdio_oe_d = mdio_oe_q;
      int_d     = int_q;
      rd_data_d = rd_data_q;
      link_d    = link_q;
      speed_d   = speed_q;
      mii_d     = mii_q;
      chg_d     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (poll_en && (int_q == 32'd0)) begin
               // Frame entry counts as the falling edge that presents bit 0.
               state_d   = StPre;
               div_d     = '0;
               mdc_d     = 1'b0;
               bit_d     = 6'd0;
               mdio_o_d  = 1'b1;
               mdio_oe_d = 1'b1;
            end
         end
         StPre, StCmd, StTa, StData: begin
            if (div_q == DivMax) begin
               div_d = '0;
               mdc_d = ~mdc_q;
               if (!mdc_q) begin
                  if (state_q == StData) shift_d = {shift_q[14:0], mdio_i};
               end else if (bit_q == 6'd63) begin
                  state_d   = StDone;
                  mdio_o_d  = 1'b1;
                  mdio_oe_d = 1'b0;
               end else begin
                  bit_d     = bit_q + 6'd1;
                  mdio_o_d  = tx_bit(bit_d);
                  mdio_oe_d = (bit_d < 6'd46);
                  state_d   = phase_of(bit_d);
               end
            end else begin
               div_d = div_q + DivW'(1);
            end
         end
         StDone: begin
            state_d   = StWait;
            int_d     = IntLoad;
            rd_data_d = shift_q;
            if (accept) begin
               link_d = new_link;
               // Reserved field 11 or link down leaves the speed selection untouched.
               if (new_link && (new_field != 2'b11) && (new_field != speed_q)) begin
                  speed_d = new_field;
                  mii_d   = (new_field != 2'b10);
                  chg_d   = 1'b1;
               end
            end
         end
         StWait: begin
            // Runs regardless of poll_en; IDLE gates the next start.
            if (int_q <= 32'd1) begin
               int_d   = 32'd0;
               state_d = StIdle;
            end else begin
               int_d = int_q - 32'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         div_q     <= '0;
         mdc_q     <= 1'b0;
         bit_q     <= 6'd0;
         shift_q   <= 16'd0;
         mdio_o_q  <= 1'b1;
         mdio_oe_q <= 1'b0;
         int_q     <= 32'd0;
         rd_data_q <= 16'd0;
         link_q    <= 1'b0;
         speed_q   <= 2'b10;
         mii_q     <= 1'b0;
         chg_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         mdc_q     <= mdc_d;
         bit_q     <= bit_d;
         shift_q   <= shift_d;
         mdio_o_q  <= mdio_o_d;
         mdio_oe_q <= mdio_oe_d;
         int_q     <= int_d;
         rd_data_q <= rd_data_d;
         link_q    <= link_d;
         speed_q   <= speed_d;
         mii_q     <= mii_d;
         chg_q     <= chg_d;
      end
   end

   assign mdc          = mdc_q;
   assign mdio_o       = mdio_o_q;
   assign mdio_oe      = mdio_oe_q;
   assign mii_select   = mii_q;
   assign speed        = speed_q;
   assign link_up      = link_q;
   assign speed_change = chg_q;
   assign rd_data      = rd_data_q;
   assign busy         = (state_q != StIdle) && (state_q != StWait);

endmodule
